// File: rtl/enc_pkg.sv
// Shared types and helpers for the sequential priority encoder.
// Holds the FSM state type and the index-width helper used to size
// the index bus from the request vector width.
package enc_pkg;

    // Largest request vector the encoder is intended for.
    localparam int ENC_MAX_N = 32;

    // Two-bit one-hot state code so that corrupted encodings
    // (00, 11) are distinguishable and can be steered back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b01,
        SCAN = 2'b10
    } enc_state_t;

    // Ceiling log2; a width of at least 1 for any value of 2 or more.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/priority_encoder_seq_if.sv
// Handshake bundle between a request producer / index consumer and the
// sequential priority encoder. The master modport is the environment side,
// the slave modport is the encoder side.
interface priority_encoder_seq_if #(
    parameter int N = 4
);
    import enc_pkg::*;

    localparam int W = clog2(N);

    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         busy;
    logic         err;

    modport master (
        output req_valid,
        output req,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_idx,
        input  out_last,
        input  busy,
        input  err
    );

    modport slave (
        input  req_valid,
        input  req,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_idx,
        output out_last,
        output busy,
        output err
    );

endinterface

// File: rtl/lsb_index_find.sv
// Combinational lowest-set-bit finder.
// Bit 0 has the highest priority. For an all-zero vector the index is 0
// and o_one_hot_or_zero is 1; callers qualify it with their own valid.
module lsb_index_find
    import enc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_vec,
    output logic [clog2(N)-1:0]  o_idx,
    output logic                 o_one_hot_or_zero
);

    localparam int W = clog2(N);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for one-hot or empty vectors.
    always_comb begin
        o_one_hot_or_zero = ((i_vec & (i_vec - N'(1))) == '0);
    end

endmodule

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: accepts a multi-hot request vector and
// emits the binary index of each set bit, lowest first, one per output
// handshake. All outputs come from registered state; req_ready is a
// plain decode of the state register.
// Optional feature macro: PRIORITY_ENCODER_SEQ_ERR_EN -- when defined,
// err pulses for one cycle after an all-zero vector is accepted; when
// undefined, err is tied low and empty vectors are dropped silently.
module priority_encoder_seq
    import enc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    priority_encoder_seq_if.slave bus
);

    localparam int W = clog2(N);

    enc_state_t   r_state;
    enc_state_t   w_stateNext;
    logic [N-1:0] r_pending;
    logic [N-1:0] w_pendingNext;
    logic [W-1:0] w_lowIdx;
    logic         w_oneHotOrZero;
    logic         w_outValid;
    logic         w_reqReady;

    lsb_index_find #(
        .N(N)
    ) u_lsbIndexFind (
        .i_vec             (r_pending),
        .o_idx             (w_lowIdx),
        .o_one_hot_or_zero (w_oneHotOrZero)
    );

    // Handshake qualifiers are pure state decodes, so no input reaches an output.
    always_comb begin
        w_reqReady = (r_state == IDLE);
        w_outValid = (r_state == SCAN);
    end

    // Next state and pending vector: load on accept, drop the lowest bit per pop.
    always_comb begin
        w_stateNext   = r_state;
        w_pendingNext = r_pending;
        case (r_state)
            IDLE: begin
                if (bus.req_valid && (bus.req != '0)) begin
                    w_pendingNext = bus.req;
                    w_stateNext   = SCAN;
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    w_pendingNext = r_pending & (r_pending - N'(1));
                    if (w_oneHotOrZero) begin
                        w_pendingNext = '0;
                        w_stateNext   = IDLE;
                    end
                end
            end
            default: begin
                w_stateNext   = IDLE;
                w_pendingNext = '0;
            end
        endcase
    end

    // State and pending registers, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_pending <= w_pendingNext;
        end
    end

`ifdef PRIORITY_ENCODER_SEQ_ERR_EN
    logic r_err;

    // One-cycle err pulse after an empty vector is taken in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_reqReady && bus.req_valid && (bus.req == '0);
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    // out_last is gated with out_valid because an empty pending reads as one-hot-or-zero.
    always_comb begin
        bus.req_ready = w_reqReady;
        bus.out_valid = w_outValid;
        bus.out_idx   = w_lowIdx;
        bus.out_last  = w_outValid & w_oneHotOrZero;
        bus.busy      = w_outValid;
    end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Testbench for priority_encoder_seq. Two instances (N=4 and N=8) share
// clock and reset. The expected index stream is kept as a queue of
// pending indices per instance, filled from the set bits of every
// accepted vector and drained on each output handshake.
// Honours PRIORITY_ENCODER_SEQ_ERR_EN for the expected err behaviour.
module tb_priority_encoder_seq;

`ifdef PRIORITY_ENCODER_SEQ_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int failures = 0;

    int q4[$];
    int q8[$];
    bit errExp4 = 1'b0;
    bit errExp8 = 1'b0;

    priority_encoder_seq_if #(.N(4)) bus4();
    priority_encoder_seq_if #(.N(8)) bus8();

    priority_encoder_seq #(.N(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    priority_encoder_seq #(.N(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic bit randReady();
        return ($urandom_range(0, 3) != 0);
    endfunction

    function automatic logic [31:0] randVec();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 5) == 0) begin
            v = 32'd0;
        end
        return v;
    endfunction

    task automatic checkReset(input string tag);
        checkOutput({tag, ".n4.req_ready"}, 32'(bus4.req_ready), 32'd1);
        checkOutput({tag, ".n4.out_valid"}, 32'(bus4.out_valid), 32'd0);
        checkOutput({tag, ".n4.out_idx"},   32'(bus4.out_idx),   32'd0);
        checkOutput({tag, ".n4.out_last"},  32'(bus4.out_last),  32'd0);
        checkOutput({tag, ".n4.busy"},      32'(bus4.busy),      32'd0);
        checkOutput({tag, ".n4.err"},       32'(bus4.err),       32'd0);
        checkOutput({tag, ".n8.req_ready"}, 32'(bus8.req_ready), 32'd1);
        checkOutput({tag, ".n8.out_valid"}, 32'(bus8.out_valid), 32'd0);
        checkOutput({tag, ".n8.out_idx"},   32'(bus8.out_idx),   32'd0);
        checkOutput({tag, ".n8.out_last"},  32'(bus8.out_last),  32'd0);
    endtask

    // Compare one instance against its queue model, then drive its inputs
    // for the coming edge and advance the model by that edge.
    task automatic stepCycle(input int inst, input bit v, input logic [31:0] vec, input bit o);
        int q[$];
        bit errExp;
        string p;
        int n;
        logic rr, ov, ol, bz, er;
        logic [31:0] idx;
        logic [31:0] masked;
        bit accept;

        if (inst == 0) begin
            q = q4; errExp = errExp4; p = "n4"; n = 4;
            rr = bus4.req_ready; ov = bus4.out_valid; ol = bus4.out_last;
            bz = bus4.busy; er = bus4.err; idx = 32'(bus4.out_idx);
        end else begin
            q = q8; errExp = errExp8; p = "n8"; n = 8;
            rr = bus8.req_ready; ov = bus8.out_valid; ol = bus8.out_last;
            bz = bus8.busy; er = bus8.err; idx = 32'(bus8.out_idx);
        end

        checkOutput({p, ".req_ready"}, 32'(rr), 32'(q.size() == 0));
        checkOutput({p, ".out_valid"}, 32'(ov), 32'(q.size() != 0));
        checkOutput({p, ".busy"},      32'(bz), 32'(q.size() != 0));
        checkOutput({p, ".out_last"},  32'(ol), 32'(q.size() == 1));
        checkOutput({p, ".err"},       32'(er), 32'(errExp));
        if (q.size() != 0) begin
            checkOutput({p, ".out_idx"}, idx, 32'(q[0]));
        end

        masked = vec & ((32'd1 << n) - 32'd1);
        if (inst == 0) begin
            bus4.req_valid = v; bus4.req = masked[3:0]; bus4.out_ready = o;
        end else begin
            bus8.req_valid = v; bus8.req = masked[7:0]; bus8.out_ready = o;
        end

        accept = v && (q.size() == 0);
        errExp = ERR_EN && accept && (masked == 32'd0);
        if ((q.size() != 0) && o) begin
            void'(q.pop_front());
        end
        if (accept && (masked != 32'd0)) begin
            for (int i = 0; i < n; i++) begin
                if (masked[i]) begin
                    q.push_back(i);
                end
            end
        end

        if (inst == 0) begin
            q4 = q; errExp4 = errExp;
        end else begin
            q8 = q; errExp8 = errExp;
        end
    endtask

    task automatic applyStimulus(input bit v4, input logic [31:0] r4, input bit o4,
                                 input bit v8, input logic [31:0] r8, input bit o8);
        @(negedge clk);
        stepCycle(0, v4, r4, o4);
        stepCycle(1, v8, r8, o8);
    endtask

    task automatic idleInputs();
        bus4.req_valid = 1'b0; bus4.req = '0; bus4.out_ready = 1'b0;
        bus8.req_valid = 1'b0; bus8.req = '0; bus8.out_ready = 1'b0;
    endtask

    // Directed scenarios first, then a long randomised run on both instances.
    initial begin
        idleInputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("init");
        rst_n = 1'b1;
        $display("[TB] reset released");

        applyStimulus(1'b1, 32'hB, 1'b1, 1'b1, 32'hFF, randReady());
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, randReady());

        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, randReady());
        repeat (3) applyStimulus(1'b1, 32'h5, 1'b0, 1'b0, 32'h0, randReady());
        applyStimulus(1'b1, 32'h5, 1'b1, 1'b0, 32'h0, randReady());
        applyStimulus(1'b1, 32'h5, 1'b1, 1'b0, 32'h0, randReady());
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, randReady());

        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, randReady());
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, randReady());

        repeat (12) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);

        applyStimulus(1'b1, 32'hF, 1'b1, 1'b1, 32'hF0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        idleInputs();
        #1;
        checkReset("midrst");
        q4.delete();
        q8.delete();
        errExp4 = 1'b0;
        errExp8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);

        $display("[TB] random phase");
        repeat (400) begin
            applyStimulus(1'($urandom_range(0, 1)), randVec(), randReady(),
                          1'($urandom_range(0, 1)), randVec(), randReady());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
